// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity modes
// and a frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks occupied on the line by one complete frame.
    function automatic int frame_clocks(input int div, input int data_bits,
                                        input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts DIV clocks per bit and pulses tick on the last
// clock of each bit. Held at reload while restart is high.
module uart_baud_tick #(
    parameter int DIV = 10417
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    generate
        if (DIV < 2 || DIV > 65535) begin : g_bad_div
            $error("uart_baud_tick: DIV must be in the range 2..65535");
        end
    endgenerate

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Auto-reload at zero lets consecutive bits run without a restart pulse.
    always_comb begin
        cnt_next = cnt_reg - CW'(1);
        if (restart || cnt_reg == '0) begin
            cnt_next = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = (cnt_reg == '0) && !restart;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with a one-entry holding register so that consecutive
// frames leave with no idle gap; bit timing comes from uart_baud_tick.
module uart_tx_frame #(
    parameter int DIV       = 10417,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] d_tx,
    input  logic                 vld_tx,
    output logic                 rdy_tx,
    output logic                 txd,
    output logic                 busy
);

    import uart_pkg::*;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in the range 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state_reg, state_next;
    logic [DATA_BITS-1:0] hold_reg, hold_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 hold_full_reg, hold_full_next;
    logic                 par_reg, par_next;
    logic [2:0]           bit_cnt_reg, bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 txd_reg, txd_next;
    logic                 tick;
    logic                 baud_restart;
    logic                 accept;
    logic                 load;

    assign baud_restart = (state_reg == IDLE);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(baud_restart),
        .tick   (tick)
    );

    assign rdy_tx = !hold_full_reg && !rst;
    assign accept = vld_tx && rdy_tx;

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        shift_next     = shift_reg;
        par_next       = par_reg;
        bit_cnt_next   = bit_cnt_reg;
        stop_cnt_next  = stop_cnt_reg;
        txd_next       = txd_reg;
        load           = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                load     = hold_full_reg;
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    txd_next     = shift_reg[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            state_next = uart_pkg::PARITY;
                            txd_next   = par_reg;
                        end else begin
                            state_next    = STOP;
                            txd_next      = 1'b1;
                            stop_cnt_next = 1'b0;
                        end
                    end else begin
                        shift_next   = shift_reg >> 1;
                        txd_next     = shift_reg[1];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_next    = STOP;
                    txd_next      = 1'b1;
                    stop_cnt_next = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_reg == LAST_STOP) begin
                        // A pending word goes straight into its start bit.
                        if (hold_full_reg) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase

        // Parity is taken from the whole word at load time, before any shifting.
        if (load) begin
            state_next     = START;
            shift_next     = hold_reg;
            par_next       = (PARITY == PAR_ODD) ? ~^hold_reg : ^hold_reg;
            hold_full_next = 1'b0;
            txd_next       = 1'b0;
        end

        if (accept) begin
            hold_next      = d_tx;
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            shift_reg     <= '0;
            par_reg       <= 1'b0;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            txd_reg       <= 1'b1;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            shift_reg     <= shift_next;
            par_reg       <= par_next;
            bit_cnt_reg   <= bit_cnt_next;
            stop_cnt_reg  <= stop_cnt_next;
            txd_reg       <= txd_next;
        end
    end

    assign txd  = txd_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8O1, 8E1 at DIV=4 and
// 5N2 at DIV=3) checked against a frame-level line model plus directed tables.
module tb_uart_tx_frame;

    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_arr [4];
    logic [3:0] vld_v;
    wire  [3:0] txd_v;
    wire  [3:0] busy_v;
    wire  [3:0] rdy_v;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .d_tx(d_arr[0]), .vld_tx(vld_v[0]),
        .rdy_tx(rdy_v[0]), .txd(txd_v[0]), .busy(busy_v[0]));

    uart_tx_frame #(.DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .d_tx(d_arr[1]), .vld_tx(vld_v[1]),
        .rdy_tx(rdy_v[1]), .txd(txd_v[1]), .busy(busy_v[1]));

    uart_tx_frame #(.DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .d_tx(d_arr[2]), .vld_tx(vld_v[2]),
        .rdy_tx(rdy_v[2]), .txd(txd_v[2]), .busy(busy_v[2]));

    uart_tx_frame #(.DIV(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .rst(rst), .d_tx(d_arr[3][4:0]), .vld_tx(vld_v[3]),
        .rdy_tx(rdy_v[3]), .txd(txd_v[3]), .busy(busy_v[3]));

    function automatic int cfg_div(input int k);
        return (k == 3) ? 3 : 4;
    endfunction
    function automatic int cfg_db(input int k);
        return (k == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_par(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction
    function automatic int cfg_sb(input int k);
        return (k == 3) ? 2 : 1;
    endfunction
    function automatic int flen(input int k);
        return (1 + cfg_db(k) + ((cfg_par(k) != 0) ? 1 : 0) + cfg_sb(k)) * cfg_div(k);
    endfunction

    // Line bits in transmission order (bit 0 first); unused high bits stay 1.
    function automatic logic [15:0] frame_bits(input int k, input logic [7:0] w);
        logic [15:0] f;
        int          n;
        int          ones;
        f    = '1;
        n    = 0;
        ones = 0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < cfg_db(k); i++) begin
            f[n] = w[i];
            ones += int'(w[i]);
            n++;
        end
        if (cfg_par(k) == 1) f[n] = ((ones % 2) == 0);
        if (cfg_par(k) == 2) f[n] = ((ones % 2) == 1);
        return f;
    endfunction

    // Frame-level model: a frame queued on the line plus a one-word holding slot.
    logic [15:0] m_frame [4];
    int          m_left  [4];
    logic        m_full  [4];
    logic [7:0]  m_hold  [4];
    logic        m_txd   [4];
    logic        m_busy  [4];
    logic        m_pre;

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rst) begin
                    m_left[k] = 0;
                    m_full[k] = 1'b0;
                    m_txd[k]  = 1'b1;
                    m_busy[k] = 1'b0;
                end else begin
                    m_pre = m_full[k];
                    if (m_left[k] == 0 && m_pre) begin
                        m_frame[k] = frame_bits(k, m_hold[k]);
                        m_left[k]  = flen(k);
                        m_full[k]  = 1'b0;
                    end
                    if (vld_v[k] && !m_pre) begin
                        m_hold[k] = d_arr[k];
                        m_full[k] = 1'b1;
                    end
                    if (m_left[k] > 0) begin
                        m_txd[k]  = m_frame[k][(flen(k) - m_left[k]) / cfg_div(k)];
                        m_busy[k] = 1'b1;
                        m_left[k]--;
                    end else begin
                        m_txd[k]  = 1'b1;
                        m_busy[k] = 1'b0;
                    end
                end
            end
        end
    end

    int busy_cyc [4] = '{0, 0, 0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (busy_v[k]) busy_cyc[k]++;
                if (chk_en) begin
                    n_vec++;
                    if (txd_v[k] !== m_txd[k] || busy_v[k] !== m_busy[k] ||
                        rdy_v[k] !== (!m_full[k] && !rst)) begin
                        n_err++;
                        $display("FAIL model dut%0d t=%0t txd/busy/rdy got %b%b%b expected %b%b%b",
                                 k, $time, txd_v[k], busy_v[k], rdy_v[k],
                                 m_txd[k], m_busy[k], !m_full[k] && !rst);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the drive/sample point just after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Presents w on DUT k and returns just after the handshake edge with vld low.
    task automatic send_word(input int k, input logic [7:0] w);
        int cnt;
        d_arr[k] = w;
        vld_v[k] = 1'b1;
        cnt = 0;
        while (!rdy_v[k] && cnt < 500) begin
            step();
            cnt++;
        end
        check($sformatf("rdy_wait dut%0d", k), int'(rdy_v[k]), 1);
        step();
        vld_v[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int cnt;
        cnt = 0;
        while ((busy_v[k] || !rdy_v[k]) && cnt < 400) begin
            step();
            cnt++;
        end
        check($sformatf("idle dut%0d", k), int'(busy_v[k]), 0);
    endtask

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [15:0] bits;
        int          nbits;
        int          len;
    } vec_t;

    vec_t tbl [8];
    int   samp [300];
    logic hs [4];

    initial begin
        int k;
        int n;
        int cnt;
        int v;
        int b0;
        int dv;

        vld_v = '0;
        for (int i = 0; i < 4; i++) begin
            d_arr[i] = 8'h00;
            hs[i]    = 1'b0;
        end

        tbl[0] = '{0, 8'h55, 16'({1'b1, 8'h55, 1'b0}), 10, 40};
        tbl[1] = '{1, 8'h07, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 44};
        tbl[2] = '{1, 8'h03, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 44};
        tbl[3] = '{2, 8'h07, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 44};
        tbl[4] = '{3, 8'hFF, 16'({2'b11, 5'h1F, 1'b0}), 8, 24};
        tbl[5] = '{2, 8'h00, 16'({1'b1, 1'b0, 8'h00, 1'b0}), 11, 44};
        tbl[6] = '{0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}), 10, 40};
        tbl[7] = '{3, 8'h0A, 16'({2'b11, 5'h0A, 1'b0}), 8, 24};

        // Reset state
        repeat (3) @(posedge clk);
        step();
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset txd dut%0d", i), int'(txd_v[i]), 1);
            check($sformatf("reset busy dut%0d", i), int'(busy_v[i]), 0);
            check($sformatf("reset rdy dut%0d", i), int'(rdy_v[i]), 0);
        end
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post-reset rdy dut%0d", i), int'(rdy_v[i]), 1);
        end

        // Table of single frames
        for (int t = 0; t < 8; t++) begin
            k = tbl[t].dut;
            for (int i = 0; i < 300; i++) samp[i] = 9;
            send_word(k, tbl[t].data);
            cnt = 0;
            while (!busy_v[k] && cnt < 20) begin
                step();
                cnt++;
            end
            n = 0;
            while (busy_v[k] && n < 300) begin
                samp[n] = int'(txd_v[k]);
                n++;
                step();
            end
            check($sformatf("len[%0d]", t), n, tbl[t].len);
            check($sformatf("pkg_len[%0d]", t),
                  frame_clocks(cfg_div(k), cfg_db(k), cfg_par(k), cfg_sb(k)), tbl[t].len);
            dv = cfg_div(k);
            for (int b = 0; b < tbl[t].nbits; b++) begin
                v = samp[b * dv];
                for (int s = 1; s < dv; s++) begin
                    if (samp[b * dv + s] != v) v = 2;
                end
                check($sformatf("bit[%0d].%0d", t, b), v, int'(tbl[t].bits[b]));
            end
            wait_idle(k);
        end

        // Back-to-back: vld held high across two words
        d_arr[0] = 8'hA5;
        vld_v[0] = 1'b1;
        cnt = 0;
        while (!rdy_v[0] && cnt < 100) begin
            step();
            cnt++;
        end
        step();
        d_arr[0] = 8'h3C;
        n = 0;
        v = 0;
        for (int c = 0; c < 200; c++) begin
            b0 = (vld_v[0] && rdy_v[0]) ? 1 : 0;
            step();
            if (b0 == 1) vld_v[0] = 1'b0;
            if (busy_v[0]) begin
                n++;
                if (n == 40) check("b2b last stop", int'(txd_v[0]), 1);
                if (n == 41) check("b2b second start", int'(txd_v[0]), 0);
                v = 1;
            end else if (v == 1) begin
                break;
            end
        end
        vld_v[0] = 1'b0;
        check("b2b busy run", n, 80);
        wait_idle(0);

        // vld while the holding register is full is ignored
        b0 = busy_cyc[0];
        send_word(0, 8'h11);
        step();
        send_word(0, 8'h22);
        check("full rdy low", int'(rdy_v[0]), 0);
        d_arr[0] = 8'h99;
        vld_v[0] = 1'b1;
        step();
        vld_v[0] = 1'b0;
        wait_idle(0);
        step();
        check("ignored word busy", busy_cyc[0] - b0, 80);

        // Reset in the middle of data bit 3 with a word pending in hold
        send_word(0, 8'hA5);
        step();
        d_arr[0] = 8'h3C;
        vld_v[0] = 1'b1;
        step();
        vld_v[0] = 1'b0;
        repeat (16) step();
        check("pre-rst txd bit3", int'(txd_v[0]), 0);
        check("pre-rst busy", int'(busy_v[0]), 1);
        rst = 1'b1;
        step();
        check("rst txd", int'(txd_v[0]), 1);
        check("rst busy", int'(busy_v[0]), 0);
        check("rst rdy", int'(rdy_v[0]), 0);
        rst = 1'b0;
        step();
        check("after rst rdy", int'(rdy_v[0]), 1);
        b0 = busy_cyc[0];
        repeat (100) step();
        check("no resume", busy_cyc[0] - b0, 0);
        check("no resume txd", int'(txd_v[0]), 1);

        // Random traffic on all four DUTs against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (vld_v[i] && hs[i]) vld_v[i] = 1'b0;
                if (!vld_v[i] && $urandom_range(0, 7) == 0) begin
                    vld_v[i]  = 1'b1;
                    d_arr[i]  = 8'($urandom);
                end
                hs[i] = vld_v[i] && rdy_v[i];
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            if (vld_v[i] && hs[i]) vld_v[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            while (vld_v[i] && cnt < 200) begin
                hs[i] = rdy_v[i];
                step();
                if (hs[i]) vld_v[i] = 1'b0;
                cnt++;
            end
            vld_v[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) wait_idle(i);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
